// File: rtl/pio_pkg.sv
// ---------------------------------------------------------------------------
// pio_pkg
// Shared definitions for the PIO state-machine scheduler and its divider.
//   sm_state_t       : scheduler FSM state encoding
//   *_DEF            : default widths for divider and instruction fields
//   DIV_ZERO_IS_MAX  : a zero integer divisor selects the maximum division
// ---------------------------------------------------------------------------
package pio_pkg;

    localparam int DIV_INT_W_DEF  = 16;
    localparam int DIV_FRAC_W_DEF = 8;
    localparam int INSTR_W_DEF    = 16;

    localparam bit DIV_ZERO_IS_MAX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DELAY = 2'd2,
        ST_IMM   = 2'd3
    } sm_state_t;

endpackage

// File: rtl/pio_clkdiv.sv
// ---------------------------------------------------------------------------
// pio_clkdiv
// Fractional (integer.fraction) clock divider producing a one-cycle tick.
// Ports:
//   clk, resetn      : clock, async active-low reset
//   en               : count enable; counter and accumulator hold when low
//   clkdiv_restart   : phase reset, next enabled cycle ticks
//   div_int          : integer divisor (0 selects 2**DIV_INT_W)
//   div_frac         : fractional divisor
//   tick             : divider strobe, combinational from en and count
// ---------------------------------------------------------------------------
module pio_clkdiv
    import pio_pkg::*;
#(
    parameter int DIV_INT_W  = DIV_INT_W_DEF,
    parameter int DIV_FRAC_W = DIV_FRAC_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  clkdiv_restart,
    input  logic [DIV_INT_W-1:0]  div_int,
    input  logic [DIV_FRAC_W-1:0] div_frac,
    output logic                  tick
);

    localparam logic [DIV_INT_W:0] CNT_ONE = {{DIV_INT_W{1'b0}}, 1'b1};
    localparam logic [DIV_INT_W:0] DIV_MAX = {1'b1, {DIV_INT_W{1'b0}}};

    logic [DIV_INT_W:0]  r_cnt;
    logic [DIV_FRAC_W-1:0] r_acc;

    logic [DIV_INT_W:0]  w_eff_int;
    logic [DIV_FRAC_W:0] w_sum;
    logic                w_carry;
    logic [DIV_INT_W:0]  w_reload;

    assign w_eff_int = (DIV_ZERO_IS_MAX && (div_int == '0)) ? DIV_MAX
                                                            : {1'b0, div_int};
    assign w_sum     = {1'b0, r_acc} + {1'b0, div_frac};
    assign w_carry   = w_sum[DIV_FRAC_W];
    // Max reload is 2**DIV_INT_W + 1, which still fits the extra count bit.
    assign w_reload  = w_eff_int + {{DIV_INT_W{1'b0}}, w_carry};

    assign tick = en && (r_cnt == CNT_ONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= CNT_ONE;
            r_acc <= '0;
        end else if (clkdiv_restart) begin
            r_cnt <= CNT_ONE;
            r_acc <= '0;
        end else if (tick) begin
            r_cnt <= w_reload;
            r_acc <= w_sum[DIV_FRAC_W-1:0];
        end else if (en) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/pio_sm_sched.sv
// ---------------------------------------------------------------------------
// pio_sm_sched
// Execution scheduler for one PIO state machine: divider-paced advance
// strobe, instruction delay countdown, forced-instruction handshake and
// program-counter restart.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | enable low, no delay pending
//   ST_RUN   | enabled, each divider tick advances the program
//   ST_DELAY | delay countdown, ticks consumed without advancing
//   ST_IMM   | forced instruction executing, ticks discarded
//
// Ports:
//   clk, resetn             : clock, async active-low reset
//   en                      : state-machine enable level
//   restart, clkdiv_restart : one-cycle restart / divider phase reset
//   div_int, div_frac       : clock divisor
//   delay, stalled          : from the current instruction / execution unit
//   imm_valid, imm_instr    : forced instruction offer
//   imm_ready               : forced instruction accepted (combinational)
//   penable                 : advance/execute strobe (combinational)
//   imm, imm_instr_out      : forced instruction executing / its word
//   pc_reset                : one-cycle PC reset strobe
//   delaying                : delay countdown in progress
// ---------------------------------------------------------------------------
module pio_sm_sched
    import pio_pkg::*;
#(
    parameter int DIV_INT_W  = DIV_INT_W_DEF,
    parameter int DIV_FRAC_W = DIV_FRAC_W_DEF,
    parameter int INSTR_W    = INSTR_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  restart,
    input  logic                  clkdiv_restart,
    input  logic [DIV_INT_W-1:0]  div_int,
    input  logic [DIV_FRAC_W-1:0] div_frac,
    input  logic [4:0]            delay,
    input  logic                  stalled,
    input  logic                  imm_valid,
    input  logic [INSTR_W-1:0]    imm_instr,
    output logic                  imm_ready,
    output logic                  penable,
    output logic                  imm,
    output logic [INSTR_W-1:0]    imm_instr_out,
    output logic                  pc_reset,
    output logic                  delaying
);

    sm_state_t          r_state;
    sm_state_t          r_ret_state;
    logic [4:0]         r_dcnt;
    logic [INSTR_W-1:0] r_imm_instr;
    logic               r_pc_reset;

    sm_state_t          w_next_state;
    sm_state_t          w_next_ret;
    sm_state_t          w_base;
    logic [4:0]         w_next_dcnt;
    logic               w_latch_imm;
    logic               w_tick;
    logic               w_run_eff;

    pio_clkdiv #(
        .DIV_INT_W  (DIV_INT_W),
        .DIV_FRAC_W (DIV_FRAC_W)
    ) u_clkdiv (
        .clk            (clk),
        .resetn         (resetn),
        .en             (en),
        .clkdiv_restart (clkdiv_restart),
        .div_int        (div_int),
        .div_frac       (div_frac),
        .tick           (w_tick)
    );

    // IDLE and RUN differ only by the enable level, so the current en picks
    // between them without a cycle of latency: the first tick after enable
    // rises already advances the program.
    assign w_run_eff = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_base    = en ? ST_RUN : ST_IDLE;

    assign penable   = w_tick && w_run_eff;
    assign imm_ready = imm_valid && w_run_eff && !restart;

    always_comb begin
        w_next_state = r_state;
        w_next_ret   = r_ret_state;
        w_next_dcnt  = r_dcnt;
        w_latch_imm  = 1'b0;

        if (restart) begin
            w_next_state = w_base;
            w_next_dcnt  = 5'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    w_next_state = w_base;
                    if (penable && !stalled && (delay != 5'd0)) begin
                        w_next_state = ST_DELAY;
                        w_next_dcnt  = delay;
                    end
                    // A forced instruction accepted alongside a delayed
                    // advance returns into that delay afterwards.
                    if (imm_ready) begin
                        w_next_ret   = w_next_state;
                        w_next_state = ST_IMM;
                        w_latch_imm  = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (w_tick) begin
                        if (r_dcnt == 5'd1) begin
                            w_next_state = ST_RUN;
                            w_next_dcnt  = 5'd0;
                        end else begin
                            w_next_dcnt  = r_dcnt - 5'd1;
                        end
                    end
                end
                ST_IMM: begin
                    if (!stalled) begin
                        w_next_state = r_ret_state;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_ret_state <= ST_IDLE;
            r_dcnt      <= 5'd0;
            r_imm_instr <= '0;
            r_pc_reset  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_dcnt      <= w_next_dcnt;
            r_pc_reset  <= restart;
            if (w_latch_imm) begin
                r_imm_instr <= imm_instr;
            end
        end
    end

    assign imm           = (r_state == ST_IMM);
    assign delaying      = (r_state == ST_DELAY);
    assign imm_instr_out = r_imm_instr;
    assign pc_reset      = r_pc_reset;

endmodule

// File: tb/tb_pio_sm_sched.sv
module tb_pio_sm_sched;

    logic        clk;
    logic        resetn;
    logic        en;
    logic        restart;
    logic        clkdiv_restart;
    logic [15:0] div_int;
    logic [7:0]  div_frac;
    logic [4:0]  delay;
    logic        stalled;
    logic        imm_valid;
    logic [15:0] imm_instr;
    logic        imm_ready;
    logic        penable;
    logic        imm;
    logic [15:0] imm_instr_out;
    logic        pc_reset;
    logic        delaying;

    pio_sm_sched dut (
        .clk            (clk),
        .resetn         (resetn),
        .en             (en),
        .restart        (restart),
        .clkdiv_restart (clkdiv_restart),
        .div_int        (div_int),
        .div_frac       (div_frac),
        .delay          (delay),
        .stalled        (stalled),
        .imm_valid      (imm_valid),
        .imm_instr      (imm_instr),
        .imm_ready      (imm_ready),
        .penable        (penable),
        .imm            (imm),
        .imm_instr_out  (imm_instr_out),
        .pc_reset       (pc_reset),
        .delaying       (delaying)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        pe;
        logic        ir;
        logic        im;
        logic        pcr;
        logic        dly;
        logic [15:0] ins;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Push the expectation for the current cycle, then move to the next one.
    task automatic chk(input string nm, input logic pe, input logic ir,
                       input logic im, input logic pcr, input logic dly,
                       input logic [15:0] ins);
        exp_t x;
        x.name = nm; x.pe = pe; x.ir = ir; x.im = im;
        x.pcr = pcr; x.dly = dly; x.ins = ins;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({penable, imm_ready, imm, pc_reset, delaying} !==
                {e.pe, e.ir, e.im, e.pcr, e.dly} || imm_instr_out !== e.ins) begin
                errors++;
                $display("FAIL %s t=%0t: got pe=%b ir=%b imm=%b pcr=%b dly=%b instr=%h, want pe=%b ir=%b imm=%b pcr=%b dly=%b instr=%h",
                         e.name, $time, penable, imm_ready, imm, pc_reset, delaying, imm_instr_out,
                         e.pe, e.ir, e.im, e.pcr, e.dly, e.ins);
            end
        end
    end

    bit p2 [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        resetn = 1'b0; en = 1'b0; restart = 1'b0; clkdiv_restart = 1'b0;
        div_int = 16'd1; div_frac = 8'd0; delay = 5'd0; stalled = 1'b0;
        imm_valid = 1'b0; imm_instr = 16'h0;
        @(posedge clk);
        #1;

        chk("reset", 0, 0, 0, 0, 0, 16'h0);
        chk("reset", 0, 0, 0, 0, 0, 16'h0);
        resetn = 1'b1;
        chk("idle", 0, 0, 0, 0, 0, 16'h0);

        // divide by 1: advance every cycle, including the enable-rise cycle
        en = 1'b1;
        repeat (6) chk("div1", 1, 0, 0, 0, 0, 16'h0);

        // divide by 2.5: periods 2,3,2,3
        div_int = 16'd2; div_frac = 8'h80; clkdiv_restart = 1'b1;
        chk("div_restart", 1, 0, 0, 0, 0, 16'h0);
        clkdiv_restart = 1'b0;
        for (int i = 0; i < 10; i++) chk("frac_div", p2[i], 0, 0, 0, 0, 16'h0);

        // delay of 3
        div_int = 16'd1; div_frac = 8'd0; clkdiv_restart = 1'b1;
        chk("div1_restart", 1, 0, 0, 0, 0, 16'h0);
        clkdiv_restart = 1'b0;
        delay = 5'd3;
        chk("dly3_issue", 1, 0, 0, 0, 0, 16'h0);
        delay = 5'd0;
        repeat (3) chk("dly3_wait", 0, 0, 0, 0, 1, 16'h0);
        chk("dly3_done", 1, 0, 0, 0, 0, 16'h0);

        // stalled advance does not load the delay
        delay = 5'd2; stalled = 1'b1;
        chk("stall_pe", 1, 0, 0, 0, 0, 16'h0);
        chk("stall_pe", 1, 0, 0, 0, 0, 16'h0);
        stalled = 1'b0;
        chk("dly2_issue", 1, 0, 0, 0, 0, 16'h0);
        delay = 5'd0;
        repeat (2) chk("dly2_wait", 0, 0, 0, 0, 1, 16'h0);
        chk("dly2_done", 1, 0, 0, 0, 0, 16'h0);

        // restart during a delay with dcnt=5
        delay = 5'd5;
        chk("dly5_issue", 1, 0, 0, 0, 0, 16'h0);
        delay = 5'd0; restart = 1'b1;
        chk("rst_in_dly", 0, 0, 0, 0, 1, 16'h0);
        restart = 1'b0;
        chk("pc_reset", 1, 0, 0, 1, 0, 16'h0);

        // restart beats a forced-instruction accept
        restart = 1'b1; imm_valid = 1'b1; imm_instr = 16'h1234;
        chk("rst_beats_imm", 1, 0, 0, 0, 0, 16'h0);
        restart = 1'b0; imm_valid = 1'b0;
        chk("rst_beats_imm2", 1, 0, 0, 1, 0, 16'h0);

        // tick and accept in the same cycle
        imm_valid = 1'b1; imm_instr = 16'hABCD;
        chk("tick_and_imm", 1, 1, 0, 0, 0, 16'h0);
        imm_valid = 1'b0;
        chk("imm_exec", 0, 0, 1, 0, 0, 16'hABCD);
        chk("imm_ret_run", 1, 0, 0, 0, 0, 16'hABCD);

        // forced instruction on a disabled state machine, stalled 2 cycles
        en = 1'b0;
        chk("en_off", 0, 0, 0, 0, 0, 16'hABCD);
        imm_valid = 1'b1; imm_instr = 16'hE001;
        chk("imm_dis_acc", 0, 1, 0, 0, 0, 16'hABCD);
        imm_valid = 1'b0; imm_instr = 16'h0; stalled = 1'b1;
        chk("imm_dis1", 0, 0, 1, 0, 0, 16'hE001);
        chk("imm_dis2", 0, 0, 1, 0, 0, 16'hE001);
        stalled = 1'b0;
        chk("imm_dis3", 0, 0, 1, 0, 0, 16'hE001);
        chk("imm_dis_end", 0, 0, 0, 0, 0, 16'hE001);

        // async reset in the middle of a forced instruction
        imm_valid = 1'b1; imm_instr = 16'h5A5A;
        chk("imm_acc2", 0, 1, 0, 0, 0, 16'hE001);
        imm_valid = 1'b0; stalled = 1'b1;
        chk("imm_acc2_exec", 0, 0, 1, 0, 0, 16'h5A5A);
        resetn = 1'b0; stalled = 1'b0;
        chk("async_rst", 0, 0, 0, 0, 0, 16'h0);
        chk("rst_hold", 0, 0, 0, 0, 0, 16'h0);
        resetn = 1'b1;
        chk("rst_rel", 0, 0, 0, 0, 0, 16'h0);
        en = 1'b1; div_int = 16'd1;
        chk("first_en", 1, 0, 0, 0, 0, 16'h0);
        chk("run_after_rst", 1, 0, 0, 0, 0, 16'h0);

        // div_int=0 divides by 65536
        div_int = 16'd0; clkdiv_restart = 1'b1;
        chk("wrap_restart", 1, 0, 0, 0, 0, 16'h0);
        clkdiv_restart = 1'b0;
        chk("wrap_t0", 1, 0, 0, 0, 0, 16'h0);
        for (int i = 1; i < 65536; i++) chk("wrap_gap", 0, 0, 0, 0, 0, 16'h0);
        chk("wrap_t65536", 1, 0, 0, 0, 0, 16'h0);

        begin
            int w;
            w = 0;
            while (q.size() != 0 && w < 10) begin
                @(posedge clk);
                w++;
            end
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
